bus_timer_array: RTL and testbench



---
 rtl/timer_array_pkg.sv | 34 +++
 rtl/timer_channel.sv | 98 +++++++++
 rtl/bus_timer_array.sv | 105 ++++++++++
 tb/tb_bus_timer_array.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_array_pkg.sv
// Shared constants and types for the bus timer array: register map, bit indices, channel state.
package timer_array_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CH_STRIDE = 8;

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_PLO  = 3'd1;
  localparam logic [2:0] OFF_PHI  = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_CLO  = 3'd4;
  localparam logic [2:0] OFF_CHI  = 3'd5;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned STAT_PEND    = 0;
  localparam int unsigned STAT_OVR     = 1;

  typedef enum logic {
    CH_STOPPED = 1'b0,
    CH_RUNNING = 1'b1
  } ch_state_e;

  // Register view of one channel as seen by the read mux.
  typedef struct packed {
    logic [7:0]       ctrl;
    logic [7:0]       plo;
    logic [7:0]       phi;
    logic [7:0]       stat;
    logic [CNT_W-1:0] cnt;
  } ch_regs_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PERIOD/STATUS registers, tick counter, run/stop FSM and IRQ flop.
module timer_channel
  import timer_array_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       wr_ctrl_i,
  input  logic       wr_plo_i,
  input  logic       wr_phi_i,
  input  logic       wr_stat_i,
  input  logic [7:0] wdata_i,
  input  logic       ack_i,
  output ch_regs_t   regs_o,
  output logic       raise_o
);

  ch_state_e        state_q, state_d;
  logic             oneshot_q, oneshot_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             raise_q, raise_d;
  logic             expire_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CH_STOPPED;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      period_q  <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      raise_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      raise_q   <= raise_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    expire_c  = 1'b0;

    // >= rather than == so a period shrunk below the count still expires.
    if (state_q == CH_RUNNING && tick_i && period_q != '0) begin
      if (cnt_q >= period_q - CNT_W'(1)) begin
        expire_c = 1'b1;
        cnt_d    = '0;
        if (oneshot_q) state_d = CH_STOPPED;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (ack_i || (wr_stat_i && wdata_i[STAT_PEND])) pend_d = 1'b0;
    if (wr_stat_i && wdata_i[STAT_OVR]) ovr_d = 1'b0;
    // Expiry outranks any clear in the same cycle.
    if (expire_c) begin
      pend_d = 1'b1;
      if (pend_q) ovr_d = 1'b1;
    end

    if (wr_ctrl_i) begin
      state_d   = wdata_i[CTRL_EN] ? CH_RUNNING : CH_STOPPED;
      oneshot_d = wdata_i[CTRL_ONESHOT];
      irq_en_d  = wdata_i[CTRL_IRQ_EN];
      if (state_q == CH_STOPPED && wdata_i[CTRL_EN]) cnt_d = '0;
    end
    if (wr_plo_i) period_d[7:0]  = wdata_i;
    if (wr_phi_i) period_d[15:8] = wdata_i;

    raise_d = pend_d & irq_en_d;
  end

  assign regs_o.ctrl = {5'b0, irq_en_q, oneshot_q, state_q == CH_RUNNING};
  assign regs_o.plo  = period_q[7:0];
  assign regs_o.phi  = period_q[15:8];
  assign regs_o.stat = {6'b0, ovr_q, pend_q};
  assign regs_o.cnt  = cnt_q;
  assign raise_o     = raise_q;

endmodule

// File: rtl/bus_timer_array.sv
// Array of N_CH bus-mapped periodic/one-shot timers with shared prescaler and registered tristate read.
// Optional macro TIMER_COUNT_READ_EN exposes each channel's live count at offsets +4/+5.
module bus_timer_array
  import timer_array_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hC0,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned PRESCALE  = 100000
) (
  input  logic            CLK,
  input  logic            RESET,
  inout  wire  [7:0]      BUS_DATA,
  input  logic [7:0]      BUS_ADDR,
  input  logic            BUS_WE,
  output logic [N_CH-1:0] IRQ_RAISE,
  input  logic [N_CH-1:0] IRQ_ACK
);

  localparam int unsigned PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam int unsigned WIN      = CH_STRIDE * N_CH;
  localparam logic [7:0]  WIN_MASK = 8'(~(WIN - 1));

  logic [PS_W-1:0] presc_q, presc_d;
  logic            tick_c;
  logic            in_win_c;
  logic [7:0]      rel_c;
  logic [2:0]      off_c;
  logic [4:0]      ch_c;
  logic            oe_q, oe_d;
  logic [7:0]      rd_q, rd_d;
  ch_regs_t        regs [N_CH];

  // Free-running timebase shared by all channels.
  assign tick_c  = (presc_q == PS_MAX);
  assign presc_d = tick_c ? '0 : presc_q + PS_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      oe_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      presc_q <= presc_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
    end
  end

  // Window is aligned to its own size, so a mask compare suffices.
  assign in_win_c = ((BUS_ADDR & WIN_MASK) == BASE_ADDR);
  assign rel_c    = BUS_ADDR - BASE_ADDR;
  assign off_c    = rel_c[2:0];
  assign ch_c     = rel_c[7:3];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel_c;
    assign sel_c = BUS_WE && in_win_c && (ch_c == 5'(i));

    timer_channel u_ch (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .tick_i    (tick_c),
      .wr_ctrl_i (sel_c && off_c == OFF_CTRL),
      .wr_plo_i  (sel_c && off_c == OFF_PLO),
      .wr_phi_i  (sel_c && off_c == OFF_PHI),
      .wr_stat_i (sel_c && off_c == OFF_STAT),
      .wdata_i   (BUS_DATA),
      .ack_i     (IRQ_ACK[i]),
      .regs_o    (regs[i]),
      .raise_o   (IRQ_RAISE[i])
    );

`ifndef TIMER_COUNT_READ_EN
    logic unused_cnt;
    assign unused_cnt = ^regs[i].cnt;
`endif
  end

  // Read mux: value sampled this cycle, presented on the bus next cycle.
  always_comb begin
    rd_d = '0;
    oe_d = 1'b0;
    if (in_win_c && !BUS_WE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_c == 5'(i)) begin
          case (off_c)
            OFF_CTRL: begin rd_d = regs[i].ctrl; oe_d = 1'b1; end
            OFF_PLO:  begin rd_d = regs[i].plo;  oe_d = 1'b1; end
            OFF_PHI:  begin rd_d = regs[i].phi;  oe_d = 1'b1; end
            OFF_STAT: begin rd_d = regs[i].stat; oe_d = 1'b1; end
`ifdef TIMER_COUNT_READ_EN
            OFF_CLO:  begin rd_d = regs[i].cnt[7:0];  oe_d = 1'b1; end
            OFF_CHI:  begin rd_d = regs[i].cnt[15:8]; oe_d = 1'b1; end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign BUS_DATA = oe_q ? rd_q : 8'bz;

endmodule

// File: tb/tb_bus_timer_array.sv
// Randomized self-checking bench for bus_timer_array against a cycle-level behavioural model.
module tb_bus_timer_array;

  localparam int         N    = 4;
  localparam int         PS   = 4;
  localparam logic [7:0] BASE = 8'hC0;
`ifdef TIMER_COUNT_READ_EN
  localparam bit CNT_RD = 1'b1;
`else
  localparam bit CNT_RD = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  wire  [7:0]   BUS_DATA;
  logic [7:0]   BUS_ADDR;
  logic         BUS_WE;
  logic [N-1:0] IRQ_RAISE;
  logic [N-1:0] IRQ_ACK;
  logic [7:0]   drv;

  assign BUS_DATA = BUS_WE ? drv : 8'bz;
  always #5 CLK = ~CLK;

  bus_timer_array #(.BASE_ADDR(BASE), .N_CH(N), .PRESCALE(PS)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUS_DATA  (BUS_DATA),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WE    (BUS_WE),
    .IRQ_RAISE (IRQ_RAISE),
    .IRQ_ACK   (IRQ_ACK)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, plain integers.
  int m_en[N], m_os[N], m_ie[N], m_per[N], m_cnt[N], m_pend[N], m_ovr[N];
  int m_ps;
  logic [N-1:0] m_raise;
  logic [7:0]   m_bus;
  bit           last_rd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_reg(input int ch, input int off);
    int v;
    case (off)
      0: v = m_ie[ch] * 4 + m_os[ch] * 2 + m_en[ch];
      1: v = m_per[ch] % 256;
      2: v = m_per[ch] / 256;
      3: v = m_ovr[ch] * 2 + m_pend[ch];
      4: v = m_cnt[ch] % 256;
      5: v = m_cnt[ch] / 256;
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic model_step();
    int rel, ch, off;
    bit in_win, tick, wr, ex, old_pend;
    int en_next;
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_per[i] = 0;
        m_cnt[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_ps = 0; m_raise = '0; m_bus = 8'bz;
      return;
    end
    in_win = (int'(BUS_ADDR) >= int'(BASE)) && (int'(BUS_ADDR) < int'(BASE) + 8 * N);
    rel = int'(BUS_ADDR) - int'(BASE);
    ch  = rel / 8;
    off = rel % 8;
    m_bus = 8'bz;
    if (!BUS_WE && in_win && (off < 4 || (CNT_RD && off < 6))) m_bus = m_reg(ch, off);
    tick = (m_ps == PS - 1);
    m_ps = tick ? 0 : m_ps + 1;
    for (int i = 0; i < N; i++) begin
      wr = BUS_WE && in_win && (ch == i);
      old_pend = (m_pend[i] != 0);
      ex = 0;
      en_next = m_en[i];
      if (m_en[i] != 0 && tick && m_per[i] != 0) begin
        if (m_cnt[i] >= m_per[i] - 1) begin
          ex = 1; m_cnt[i] = 0;
          if (m_os[i] != 0) en_next = 0;
        end else m_cnt[i]++;
      end
      if (IRQ_ACK[i] || (wr && off == 3 && drv[0])) m_pend[i] = 0;
      if (wr && off == 3 && drv[1]) m_ovr[i] = 0;
      if (ex) begin
        if (old_pend) m_ovr[i] = 1;
        m_pend[i] = 1;
      end
      if (wr && off == 0) begin
        if (m_en[i] == 0 && drv[0]) m_cnt[i] = 0;
        en_next = int'(drv[0]); m_os[i] = int'(drv[1]); m_ie[i] = int'(drv[2]);
      end
      if (wr && off == 1) m_per[i] = (m_per[i] / 256) * 256 + int'(drv);
      if (wr && off == 2) m_per[i] = (m_per[i] % 256) + int'(drv) * 256;
      m_en[i] = en_next;
      m_raise[i] = (m_pend[i] != 0) && (m_ie[i] != 0);
    end
  endtask

  // One bus cycle: drive, clock, update model, compare on the falling edge.
  task automatic cyc(input logic we, input logic [7:0] a, input logic [7:0] d,
                     input logic [N-1:0] ack, input logic rst);
    BUS_WE = we; BUS_ADDR = a; drv = d; IRQ_ACK = ack; RESET = rst;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("irq", 16'(IRQ_RAISE), 16'(m_raise));
    if (!we) check("bus", {8'h00, BUS_DATA}, {8'h00, m_bus});
    last_rd = !we && !rst;
  endtask

  // A turnaround cycle keeps a pending read drive off the bus during a write.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    if (last_rd) cyc(1'b0, 8'h00, 8'h00, '0, 1'b0);
    cyc(1'b1, a, d, '0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    cyc(1'b0, a, 8'h00, '0, 1'b0);
    v = BUS_DATA;
  endtask

  task automatic idle(input int n, input logic [N-1:0] ack);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 8'h00, (k == 0) ? ack : '0, 1'b0);
  endtask

  logic [7:0] v;
  logic [7:0] zz;
  int         waited;

  initial begin
    zz = 8'bz;
    BUS_WE = 1'b0; BUS_ADDR = 8'h00; drv = 8'h00; IRQ_ACK = '0; RESET = 1'b1;
    last_rd = 1'b0;
    cyc(1'b0, 8'h00, 8'h00, '0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, '0, 1'b1);
    check("rst_irq", 16'(IRQ_RAISE), 16'h0000);

    // ch0 periodic with IRQ, rise then ack
    wr(8'hC1, 8'd3); wr(8'hC2, 8'd0); wr(8'hC0, 8'h05);
    waited = 0;
    while (IRQ_RAISE[0] !== 1'b1 && waited < 40) begin idle(1, '0); waited++; end
    check("ch0_rise", 16'(IRQ_RAISE[0]), 16'h0001);
    idle(1, 4'b0001);
    check("ch0_ack_fall", 16'(IRQ_RAISE[0]), 16'h0000);

    // ack landing on the exact expiry cycle
    waited = 0;
    while (!(m_ps == PS - 1 && m_cnt[0] >= m_per[0] - 1) && waited < 64) begin
      idle(1, '0); waited++;
    end
    check("ch0_expiry_found", 16'(waited < 64), 16'h0001);
    idle(1, 4'b0001);
    check("ch0_ack_vs_expire", 16'(IRQ_RAISE[0]), 16'h0001);

    // ch1 one-shot
    wr(8'hC9, 8'd2); wr(8'hCA, 8'd0); wr(8'hC8, 8'h07);
    idle(20, '0);
    rd(8'hC8, v);
    check("ch1_ctrl_after_oneshot", {8'h00, v}, 16'h0006);
    idle(1, 4'b0010);
    idle(200, '0);
    check("ch1_no_rearm", 16'(IRQ_RAISE[1]), 16'h0000);
    rd(8'hCB, v);
    check("ch1_stat", {8'h00, v}, 16'h0000);

    // ch2 overrun, then W1C of OVR and ack of PEND
    wr(8'hD1, 8'd1); wr(8'hD2, 8'd0); wr(8'hD0, 8'h01);
    idle(12, '0);
    wr(8'hD0, 8'h00);
    rd(8'hD3, v);
    check("ch2_stat_ovr", {8'h00, v}, 16'h0003);
    wr(8'hD3, 8'h02);
    rd(8'hD3, v);
    check("ch2_stat_w1c", {8'h00, v}, 16'h0001);
    idle(1, 4'b0100);
    rd(8'hD3, v);
    check("ch2_stat_ack", {8'h00, v}, 16'h0000);

    // read path boundaries
    wr(8'hC2, 8'h5A);
    rd(8'hC2, v);
    check("ch0_phi_read", {8'h00, v}, 16'h005A);
    wr(8'hC2, 8'h00);
    rd(8'hC6, v);
    check("reserved_z", {8'h00, v}, {8'h00, zz});
    rd(8'h40, v);
    check("outside_z", {8'h00, v}, {8'h00, zz});
    rd(8'hE0, v);
    check("above_win_z", {8'h00, v}, {8'h00, zz});
    rd(8'hC4, v); idle(4, '0); rd(8'hC4, v);

    // reset in the middle of a count with PEND set
    waited = 0;
    while (IRQ_RAISE[0] !== 1'b1 && waited < 40) begin idle(1, '0); waited++; end
    cyc(1'b0, 8'h00, 8'h00, '0, 1'b1);
    check("reset_irq", 16'(IRQ_RAISE), 16'h0000);
    rd(8'hC0, v); check("reset_ctrl", {8'h00, v}, 16'h0000);
    rd(8'hC1, v); check("reset_plo", {8'h00, v}, 16'h0000);
    rd(8'hC3, v); check("reset_stat", {8'h00, v}, 16'h0000);
    idle(40, '0);
    check("reset_quiet", 16'(IRQ_RAISE), 16'h0000);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] a, d;
      logic [N-1:0] ack;
      r = int'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 31));
      case (a[2:0])
        3'd1:    d = 8'($urandom_range(0, 5));
        3'd2:    d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 1)) : 8'h00;
        default: d = 8'($urandom);
      endcase
      ack = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 499) == 0) cyc(1'b0, 8'h00, 8'h00, '0, 1'b1);
      else if (r <= 2) wr(a, d);
      else if (r <= 5) rd(a, v);
      else idle(1, ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
